// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS instruction/data memory arbiter: FSM state
// encoding, requester port ids and default address/data widths.
package mips_mem_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_ACCESS = 2'd1;
  localparam arb_state_t ST_DONE   = 2'd2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_arb_wait_timer.sv
// Loadable down-counter that counts the memory wait states of one access and
// flags when the read data is due.
module mem_arb_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between instruction fetch
// and data ports; define MIPS_MEM_ARB_STATS_EN to add grant/conflict counters.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int WAIT_STATES = 1,
  parameter int STARVE_MAX  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MIPS_MEM_ARB_STATS_EN
  ,
  output logic [15:0]   if_grant_cnt,
  output logic [15:0]   d_grant_cnt,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int TW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  arb_state_t    state_q, state_d;
  logic          port_q, port_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic tmr_load, tmr_dec, tmr_zero;
  logic pick_d;

  // Data wins unless fetch is waiting and has already lost STARVE_MAX times.
  assign pick_d = d_req && !(if_req && (starve_q == SW'(STARVE_MAX)));

  mem_arb_wait_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (TW'(WAIT_STATES)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d     = state_q;
    port_d      = port_q;
    starve_d    = starve_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!halted && (if_req || d_req)) begin
          port_d     = pick_d ? PORT_D : PORT_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = pick_d && d_we;
          mem_addr_d = pick_d ? d_addr : if_addr;
          if (pick_d) begin
            mem_wdata_d = d_wdata;
            if (if_req && (starve_q != SW'(STARVE_MAX)))
              starve_d = starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
          tmr_load = 1'b1;
          state_d  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (tmr_zero) begin
          if (port_q == PORT_IF)
            if_rdata_d = mem_rdata;
          else if (!mem_we_q)
            d_rdata_d = mem_rdata;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if_ack_d = (port_q == PORT_IF);
          d_ack_d  = (port_q == PORT_D);
          state_d  = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the asynchronous reset clears all state, so an in-flight access is dropped without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_IF;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef MIPS_MEM_ARB_STATS_EN
  logic        stat_grant;
  logic [15:0] if_cnt_q, d_cnt_q, conf_cnt_q;

  assign stat_grant = (state_q == ST_IDLE) && !halted && (if_req || d_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_cnt_q   <= '0;
      d_cnt_q    <= '0;
      conf_cnt_q <= '0;
    end else if (stat_grant) begin
      if ((port_d == PORT_IF) && (if_cnt_q != 16'hFFFF)) if_cnt_q <= if_cnt_q + 16'd1;
      if ((port_d == PORT_D) && (d_cnt_q != 16'hFFFF))   d_cnt_q  <= d_cnt_q + 16'd1;
      if (if_req && d_req && (conf_cnt_q != 16'hFFFF))   conf_cnt_q <= conf_cnt_q + 16'd1;
    end
  end

  assign if_grant_cnt = if_cnt_q;
  assign d_grant_cnt  = d_cnt_q;
  assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: memory model, scoreboard of expected
// acks, and checks of latency, priority, starvation, halt and reset behaviour.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int WS   = 1;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          halted;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
`ifdef MIPS_MEM_ARB_STATS_EN
  logic [15:0]   if_grant_cnt, d_grant_cnt, conflict_cnt;
`endif

  mips_mem_arbiter #(
    .AW(AW), .DW(DW), .WAIT_STATES(WS), .STARVE_MAX(SMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .halted    (halted),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef MIPS_MEM_ARB_STATS_EN
    ,
    .if_grant_cnt (if_grant_cnt),
    .d_grant_cnt  (d_grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    return (a == 10'd5) ? 32'h2801000a : {16'hC0DE, 6'd0, a};
  endfunction

  // Memory with one wait state: data registered the cycle after mem_en is seen.
  logic [DW-1:0] wmem [1024];
  bit            wvalid [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wmem[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
      end
      mem_rdata <= wvalid[mem_addr] ? wmem[mem_addr] : exp_word(mem_addr);
    end
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  bit            hold_reqs = 1'b0;
  logic [DW-1:0] d_model = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Steps negedges until an ack; pops the scoreboard and compares port/data.
  task automatic wait_ack(input string tag, output int ack_cyc, output int en_cnt, output int we_cnt);
    bit   got = 1'b0;
    exp_t e;
    ack_cyc = 0;
    en_cnt  = 0;
    we_cnt  = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
      if (if_ack || d_ack) begin
        got     = 1'b1;
        ack_cyc = c;
        check({tag, "_one_ack"}, {63'd0, (if_ack && d_ack)}, 64'd0);
        if (sb_q.size() == 0) begin
          check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check({tag, "_port"}, {63'd0, (d_ack ? PORT_D : PORT_IF)}, {63'd0, e.port});
          check({tag, "_data"}, {32'd0, ((e.port == PORT_D) ? d_rdata : if_rdata)}, {32'd0, e.data});
          if (e.port == PORT_D) d_model = e.data;
        end
        if (!hold_reqs) begin
          if (if_ack) if_req = 1'b0;
          if (d_ack)  d_req  = 1'b0;
        end
      end
    end
    check({tag, "_ack_seen"}, {63'd0, got}, 64'd1);
  endtask

  initial begin
    int ac, en, we, seen;

    rst_n   = 1'b0;
    halted  = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_if_ack",   {63'd0, if_ack}, 64'd0);
    check("rst_d_ack",    {63'd0, d_ack},  64'd0);
    check("rst_mem_en",   {63'd0, mem_en}, 64'd0);
    check("rst_mem_we",   {63'd0, mem_we}, 64'd0);
    check("rst_busy",     {63'd0, busy},   64'd0);
    check("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
    check("rst_rdata",    {if_rdata, d_rdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch only: two mem_en cycles, ack on cycle 3
    if_addr = 10'd5;
    if_req  = 1'b1;
    push_exp(PORT_IF, 32'h2801000a);
    wait_ack("fetch", ac, en, we);
    check("fetch_lat",    64'(ac), 64'(WS + 2));
    check("fetch_en_cyc", 64'(en), 64'(WS + 1));
    @(negedge clk);
    check("fetch_ack_pulse", {63'd0, if_ack}, 64'd0);
    check("fetch_hold",      {32'd0, if_rdata}, {32'd0, 32'h2801000a});

    // Store then back-to-back load of the same word
    d_we = 1'b1; d_addr = 10'd20; d_wdata = 32'h1E; d_req = 1'b1;
    push_exp(PORT_D, d_model);
    wait_ack("store", ac, en, we);
    check("store_we_cyc", 64'(we), 64'(WS + 1));
    check("store_mem",    {32'd0, (wvalid[20] ? wmem[20] : 32'hDEAD_BEEF)}, {32'd0, 32'h1E});
    d_we = 1'b0; d_req = 1'b1;
    push_exp(PORT_D, 32'h1E);
    wait_ack("load", ac, en, we);
    check("load_we_cyc", 64'(we), 64'd0);
    check("load_tput",   64'(ac), 64'(WS + 3));
    @(negedge clk);

    // Contention: both held, data wins STARVE_MAX times then fetch is forced
    hold_reqs = 1'b1;
    if_addr = 10'd7; d_addr = 10'd9; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 8; i++)
      push_exp(((i % 4) == 3) ? PORT_IF : PORT_D, ((i % 4) == 3) ? exp_word(10'd7) : exp_word(10'd9));
    for (int i = 0; i < 8; i++) begin
      wait_ack($sformatf("contend%0d", i), ac, en, we);
      if (i > 0) check($sformatf("contend%0d_tput", i), 64'(ac), 64'(WS + 3));
    end
    if_req = 1'b0; d_req = 1'b0;
    hold_reqs = 1'b0;
    @(negedge clk);

    // Halt raised mid data access: data completes, pending fetch is blocked
    d_addr = 10'd30; if_addr = 10'd5; d_we = 1'b0;
    d_req = 1'b1; if_req = 1'b1;
    push_exp(PORT_D, exp_word(10'd30));
    @(negedge clk);
    check("halt_in_access", {63'd0, mem_en}, 64'd1);
    halted = 1'b1;
    wait_ack("halt_d", ac, en, we);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || mem_en || if_ack) seen++;
    end
    check("halt_blocked", 64'(seen), 64'd0);
    halted = 1'b0;
    push_exp(PORT_IF, 32'h2801000a);
    wait_ack("halt_release", ac, en, we);
    @(negedge clk);

    // Reset during ACCESS aborts without ack; held request restarts
    d_addr = 10'd40; d_we = 1'b0; d_req = 1'b1;
    @(negedge clk);
    check("rstmid_pre_en", {63'd0, mem_en}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_en_drop", {63'd0, mem_en}, 64'd0);
    check("rstmid_busy",    {63'd0, busy},   64'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (d_ack || if_ack || mem_en) seen++;
    end
    check("rstmid_no_ack", 64'(seen), 64'd0);
    rst_n   = 1'b1;
    d_model = '0;
    push_exp(PORT_D, exp_word(10'd40));
    wait_ack("rstmid_restart", ac, en, we);
    check("rstmid_lat", 64'(ac), 64'(WS + 2));
    @(negedge clk);

`ifdef MIPS_MEM_ARB_STATS_EN
    // Statistics: 4 fetches, 2 loads, exactly one contended grant
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("stats_rst", {16'd0, if_grant_cnt, d_grant_cnt, conflict_cnt}, 64'd0);
    for (int a = 1; a <= 3; a++) begin
      if_addr = 10'(a); if_req = 1'b1;
      push_exp(PORT_IF, exp_word(10'(a)));
      wait_ack($sformatf("stats_f%0d", a), ac, en, we);
    end
    d_addr = 10'd4; d_we = 1'b0; d_req = 1'b1;
    push_exp(PORT_D, exp_word(10'd4));
    wait_ack("stats_l1", ac, en, we);
    @(negedge clk);
    if_addr = 10'd6; d_addr = 10'd8; if_req = 1'b1; d_req = 1'b1;
    push_exp(PORT_D, exp_word(10'd8));
    push_exp(PORT_IF, exp_word(10'd6));
    wait_ack("stats_c_d", ac, en, we);
    wait_ack("stats_c_if", ac, en, we);
    @(negedge clk);
    check("stats_if_cnt",   64'(if_grant_cnt), 64'd4);
    check("stats_d_cnt",    64'(d_grant_cnt),  64'd2);
    check("stats_conflict", 64'(conflict_cnt), 64'd1);
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
